// File: rtl/game_pkg.sv
// Shared constants for the falling-block game controller: state encoding,
// LFSR seed, fall speed cap and drop_x placement offset.
package game_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   localparam logic [9:0] LFSR_SEED  = 10'h1A5;
   localparam logic [3:0] SPEED_CAP  = 4'd8;
   localparam logic [9:0] DROP_X_OFS = 10'd32;

   // Fall speed grows by one every 8 points, capped.
   function automatic logic [3:0] fall_speed(input logic [7:0] score);
      logic [5:0] raw;
      raw = 6'd2 + {1'b0, score[7:3]};
      return (raw > {2'b00, SPEED_CAP}) ? SPEED_CAP : raw[3:0];
   endfunction

   // 10-bit maximal Fibonacci LFSR, taps 10 and 7.
   function automatic logic [9:0] lfsr_step(input logic [9:0] cur);
      return {cur[8:0], cur[9] ^ cur[6]};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, optional debouncer, press pulse.
// The debouncer is only built when GAME_CTRL_DEBOUNCE_EN is defined.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic btn,
   output logic level,
   output logic press
);

   logic [1:0] sync;
   logic       level_d;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], btn};
      end
   end

`ifdef GAME_CTRL_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;
   logic          level_q;

   // Down-counter runs only while the synchronized input disagrees with the
   // accepted level; any agreeing sample restarts the window.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt     <= RELOAD;
         level_q <= 1'b0;
      end else if (sync[1] != level_q) begin
         if (cnt == '0) begin
            level_q <= sync[1];
            cnt     <= RELOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end else begin
         cnt <= RELOAD;
      end
   end

   assign level = level_q;
`else
   assign level = sync[1];
`endif

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         level_d <= 1'b0;
      end else begin
         level_d <= level;
      end
   end

   assign press = level & ~level_d;

endmodule

// File: rtl/game_ctrl.sv
// Falling-block game controller: player movement, drop fall/respawn, scoring.
// Define GAME_CTRL_DEBOUNCE_EN to build the button debouncers.
//
//   state | meaning
//   IDLE  | waiting for any button press to start a game
//   PLAY  | per-frame movement, fall and respawn; collision ends the game
//   OVER  | everything frozen; press one button while holding the other
module game_ctrl
   import game_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int X_MAX           = 600,
   parameter int PLAYER_STEP     = 4,
   parameter int Y_BOTTOM        = 480
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       frame_tick,
   input  logic       collision,
   output logic [9:0] player_x,
   output logic [9:0] drop_x,
   output logic [9:0] drop_y,
   output logic [7:0] score,
   output logic [1:0] state,
   output logic       game_over
);

   localparam logic [9:0]  X_MAX_V  = 10'(X_MAX);
   localparam logic [9:0]  X_MID    = 10'(X_MAX / 2);
   localparam logic [9:0]  STEP_V   = 10'(PLAYER_STEP);
   localparam logic [10:0] Y_BOT_V  = 11'(Y_BOTTOM);

   logic       lvl_left, lvl_right;
   logic       press_left, press_right;
   logic [9:0] lfsr;
   logic [9:0] x_next;
   logic [10:0] y_sum;
   logic [9:0] spawn_x;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .btn       (btn_left),
      .level     (lvl_left),
      .press     (press_left)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .btn       (btn_right),
      .level     (lvl_right),
      .press     (press_right)
   );

   assign spawn_x = DROP_X_OFS + {1'b0, lfsr[8:0]};
   assign y_sum   = {1'b0, drop_y} + {7'd0, fall_speed(score)};

   always_comb begin
      x_next = player_x;
      if (lvl_left && !lvl_right) begin
         x_next = (player_x < STEP_V) ? 10'd0 : player_x - STEP_V;
      end else if (lvl_right && !lvl_left) begin
         x_next = (player_x > X_MAX_V - STEP_V) ? X_MAX_V : player_x + STEP_V;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state    <= ST_IDLE;
         player_x <= X_MID;
         drop_x   <= 10'd0;
         drop_y   <= 10'd0;
         score    <= 8'd0;
         lfsr     <= LFSR_SEED;
      end else begin
         lfsr <= lfsr_step(lfsr);
         case (state)
            ST_IDLE: begin
               if (press_left || press_right) begin
                  state    <= ST_PLAY;
                  player_x <= X_MID;
                  drop_x   <= spawn_x;
                  drop_y   <= 10'd0;
                  score    <= 8'd0;
               end
            end
            ST_PLAY: begin
               if (frame_tick) begin
                  // Collision wins over movement, fall and a same-frame respawn.
                  if (collision) begin
                     state <= ST_OVER;
                  end else begin
                     player_x <= x_next;
                     if (y_sum >= Y_BOT_V) begin
                        drop_y <= 10'd0;
                        drop_x <= spawn_x;
                        if (score != 8'hFF) score <= score + 8'd1;
                     end else begin
                        drop_y <= y_sum[9:0];
                     end
                  end
               end
            end
            ST_OVER: begin
               if ((press_left && lvl_right) || (press_right && lvl_left)) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign game_over = (state == ST_OVER);

endmodule

// File: tb/tb_game_ctrl.sv
// Directed self-checking bench for game_ctrl with a short debounce window.
module tb_game_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       btn_left = 1'b0;
   logic       btn_right = 1'b0;
   logic       frame_tick = 1'b0;
   logic       collision = 1'b0;
   logic [9:0] player_x, drop_x, drop_y;
   logic [7:0] score;
   logic [1:0] state;
   logic       game_over;

   int tests = 0;
   int fails = 0;

   game_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .X_MAX           (600),
      .PLAYER_STEP     (4),
      .Y_BOTTOM        (480)
   ) dut (
      .sys_clk    (sys_clk),
      .sys_rst_n  (sys_rst_n),
      .btn_left   (btn_left),
      .btn_right  (btn_right),
      .frame_tick (frame_tick),
      .collision  (collision),
      .player_x   (player_x),
      .drop_x     (drop_x),
      .drop_y     (drop_y),
      .score      (score),
      .state      (state),
      .game_over  (game_over)
   );

   always #10 sys_clk = ~sys_clk;

   task automatic idle(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic ticks(input int n, input logic coll);
      for (int i = 0; i < n; i++) begin
         @(negedge sys_clk);
         frame_tick = 1'b1;
         collision  = coll;
         @(negedge sys_clk);
         frame_tick = 1'b0;
         collision  = 1'b0;
         idle(1);
      end
   endtask

   task automatic press_left;
      btn_left = 1'b1; idle(20);
      btn_left = 1'b0; idle(20);
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b0;
      idle(3);
      tests++;
      if (state !== 2'd0 || player_x !== 10'd300 || drop_x !== 10'd0 ||
          drop_y !== 10'd0 || score !== 8'd0 || game_over !== 1'b0) begin
         fails++;
         $display("FAIL reset: state=%0d px=%0d dx=%0d dy=%0d score=%0d go=%0b, need 0/300/0/0/0/0",
                  state, player_x, drop_x, drop_y, score, game_over);
      end
      sys_rst_n = 1'b1;
      idle(20);
      tests++;
      if (state !== 2'd0) begin
         fails++;
         $display("FAIL idle_after_reset: state=%0d need 0", state);
      end
   endtask

   task automatic test_start;
      press_left();
      tests++;
      if (state !== 2'd1 || player_x !== 10'd300 || score !== 8'd0 || drop_y !== 10'd0) begin
         fails++;
         $display("FAIL start: state=%0d px=%0d score=%0d dy=%0d, need 1/300/0/0",
                  state, player_x, score, drop_y);
      end
      tests++;
      if (drop_x < 10'd32 || drop_x > 10'd543) begin
         fails++;
         $display("FAIL start_drop_x: dx=%0d need 32..543", drop_x);
      end
   endtask

   task automatic test_move;
      btn_right = 1'b1; idle(20);
      ticks(74, 1'b0);
      tests++;
      if (player_x !== 10'd596) begin
         fails++;
         $display("FAIL move_right_74: px=%0d need 596", player_x);
      end
      ticks(126, 1'b0);
      tests++;
      if (player_x !== 10'd600 || drop_y !== 10'd400) begin
         fails++;
         $display("FAIL move_right_clamp: px=%0d dy=%0d need 600/400", player_x, drop_y);
      end
      btn_right = 1'b0; btn_left = 1'b1; idle(20);
      ticks(10, 1'b0);
      tests++;
      if (player_x !== 10'd560 || drop_y !== 10'd420) begin
         fails++;
         $display("FAIL move_left: px=%0d dy=%0d need 560/420", player_x, drop_y);
      end
      btn_right = 1'b1; idle(20);
      ticks(5, 1'b0);
      tests++;
      if (player_x !== 10'd560 || drop_y !== 10'd430) begin
         fails++;
         $display("FAIL move_both: px=%0d dy=%0d need 560/430", player_x, drop_y);
      end
      btn_left = 1'b0; btn_right = 1'b0; idle(20);
      tests++;
      if (state !== 2'd1) begin
         fails++;
         $display("FAIL release_in_play: state=%0d need 1", state);
      end
   endtask

   task automatic test_fall;
      ticks(24, 1'b0);
      tests++;
      if (drop_y !== 10'd478 || score !== 8'd0) begin
         fails++;
         $display("FAIL fall_239: dy=%0d score=%0d need 478/0", drop_y, score);
      end
      ticks(1, 1'b0);
      tests++;
      if (drop_y !== 10'd0 || score !== 8'd1 || drop_x < 10'd32 || drop_x > 10'd543) begin
         fails++;
         $display("FAIL respawn_240: dy=%0d score=%0d dx=%0d need 0/1/32..543",
                  drop_y, score, drop_x);
      end
      ticks(7 * 240, 1'b0);
      tests++;
      if (drop_y !== 10'd0 || score !== 8'd8) begin
         fails++;
         $display("FAIL score8: dy=%0d score=%0d need 0/8", drop_y, score);
      end
      ticks(1, 1'b0);
      tests++;
      if (drop_y !== 10'd3) begin
         fails++;
         $display("FAIL step3: dy=%0d need 3", drop_y);
      end
   endtask

   task automatic test_collision;
      ticks(158, 1'b0);
      tests++;
      if (drop_y !== 10'd477 || score !== 8'd8) begin
         fails++;
         $display("FAIL pre_respawn: dy=%0d score=%0d need 477/8", drop_y, score);
      end
      ticks(1, 1'b1);
      tests++;
      if (state !== 2'd2 || game_over !== 1'b1 || score !== 8'd8 || drop_y !== 10'd477) begin
         fails++;
         $display("FAIL collide_on_respawn: state=%0d go=%0b score=%0d dy=%0d need 2/1/8/477",
                  state, game_over, score, drop_y);
      end
      ticks(3, 1'b0);
      tests++;
      if (state !== 2'd2 || drop_y !== 10'd477 || player_x !== 10'd560 || score !== 8'd8) begin
         fails++;
         $display("FAIL over_frozen: state=%0d dy=%0d px=%0d score=%0d need 2/477/560/8",
                  state, drop_y, player_x, score);
      end
   endtask

   task automatic test_over_exit;
      press_left();
      tests++;
      if (state !== 2'd2) begin
         fails++;
         $display("FAIL single_press: state=%0d need 2", state);
      end
      btn_right = 1'b1; idle(20);
      tests++;
      if (state !== 2'd2) begin
         fails++;
         $display("FAIL right_alone: state=%0d need 2", state);
      end
      press_left();
      tests++;
      if (state !== 2'd0 || game_over !== 1'b0) begin
         fails++;
         $display("FAIL combo_exit: state=%0d go=%0b need 0/0", state, game_over);
      end
      btn_right = 1'b0; idle(20);
      ticks(2, 1'b1);
      tests++;
      if (state !== 2'd0) begin
         fails++;
         $display("FAIL collision_idle: state=%0d need 0", state);
      end
   endtask

   task automatic test_bounce;
`ifdef GAME_CTRL_DEBOUNCE_EN
      for (int i = 0; i < 8; i++) begin
         btn_left = 1'b1; idle(2);
         btn_left = 1'b0; idle(2);
      end
      idle(20);
      tests++;
      if (state !== 2'd0) begin
         fails++;
         $display("FAIL bounce: state=%0d need 0", state);
      end
`endif
   endtask

   task automatic test_reset_mid_play;
      press_left();
      btn_right = 1'b1; idle(20);
      ticks(1, 1'b0);
      tests++;
      if (state !== 2'd1 || player_x !== 10'd304 || drop_y !== 10'd2) begin
         fails++;
         $display("FAIL replay: state=%0d px=%0d dy=%0d need 1/304/2", state, player_x, drop_y);
      end
      sys_rst_n = 1'b0;
      #1;
      tests++;
      if (state !== 2'd0 || player_x !== 10'd300 || drop_x !== 10'd0 ||
          drop_y !== 10'd0 || score !== 8'd0 || game_over !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_play: state=%0d px=%0d dx=%0d dy=%0d score=%0d go=%0b",
                  state, player_x, drop_x, drop_y, score, game_over);
      end
      btn_right = 1'b0;
      idle(3);
      sys_rst_n = 1'b1;
      idle(30);
      tests++;
      if (state !== 2'd0) begin
         fails++;
         $display("FAIL no_residual_press: state=%0d need 0", state);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_move();
      test_fall();
      test_collision();
      test_over_exit();
      test_bounce();
      test_reset_mid_play();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
